// File: rtl/cpu_pkg.sv
// Shared CPU parameter defaults and width helpers, used by the regfile scoreboard and the ID stage.
// Pure declarations: no logic, no latency, no flow control.
// Widths derive from register count and pending depth so both stages agree.
package cpu_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int NREG_DEF    = 32;
    localparam int NRD_DEF     = 2;
    localparam int MAXPEND_DEF = 3;

    function automatic int aw_f(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

    function automatic int cw_f(input int maxpend);
        return (maxpend > 0) ? $clog2(maxpend + 1) : 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Issue/writeback/status bundle between the ID stage and the regfile scoreboard.
// Wires only: no latency; issue_ready is the only backpressure signal.
// master = ID stage side, slave = scoreboard side.
interface regfile_scoreboard_if
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NRD  = NRD_DEF,
    parameter int AW   = aw_f(NREG_DEF)
);
    logic                issue_valid;
    logic [AW-1:0]       issue_dst;
    logic [NRD*AW-1:0]   issue_src;
    logic                issue_ready;
    logic [NRD*XLEN-1:0] rd_data;
    logic                wb_valid;
    logic [AW-1:0]       wb_reg;
    logic [XLEN-1:0]     wb_data;
    logic                flush;
    logic                busy;
    logic                err_underflow;

    modport master (
        output issue_valid, issue_dst, issue_src, wb_valid, wb_reg, wb_data, flush,
        input  issue_ready, rd_data, busy, err_underflow
    );

    modport slave (
        input  issue_valid, issue_dst, issue_src, wb_valid, wb_reg, wb_data, flush,
        output issue_ready, rd_data, busy, err_underflow
    );
endinterface

// File: rtl/sb_counter.sv
// Per-register pending-write counter: saturating up/down with synchronous clear.
// One cycle from inc/dec/clr to the new count; underflow is combinational.
// No backpressure; the caller must not inc at MAXPEND (the counter holds if it does).
module sb_counter #(
    parameter int CW      = 2,
    parameter int MAXPEND = 3
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          underflow
);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAXPEND);

    // A dec with nothing pending is an error unless a flush is discarding tracking anyway.
    assign underflow = dec && !clr && (cnt == '0);

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec && (cnt != CNT_MAX)) begin
            cnt <= cnt + CW'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write scoreboard and write-through read bypass.
// Reads and issue_ready are combinational; writes/counters update at the next CLOCK edge.
// issue_ready stalls issue on unresolved source hazards, destination saturation or flush.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NREG    = NREG_DEF,
    parameter int NRD     = NRD_DEF,
    parameter int MAXPEND = MAXPEND_DEF
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    regfile_scoreboard_if.slave  sb
);
    localparam int AW = aw_f(NREG);
    localparam int CW = cw_f(MAXPEND);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAXPEND);

    logic [XLEN-1:0] regs [NREG];
    logic [CW-1:0]   cnt  [NREG];
    logic [NREG-1:0] inc, dec, uflow;
    logic            wb_en, fire, rdy, busy, err;

    assign wb_en = sb.wb_valid && (sb.wb_reg != '0);
    assign fire  = sb.issue_valid && rdy;

    assign regs[0]  = '0;
    assign cnt[0]   = '0;
    assign inc[0]   = 1'b0;
    assign dec[0]   = 1'b0;
    assign uflow[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_reg
        logic [XLEN-1:0] q;

        assign inc[i]  = fire && (sb.issue_dst == AW'(i));
        assign dec[i]  = sb.wb_valid && (sb.wb_reg == AW'(i));
        assign regs[i] = q;

        always_ff @(posedge CLOCK or negedge RESET) begin
            if (!RESET) q <= '0;
            else if (dec[i]) q <= sb.wb_data;
        end

        sb_counter #(.CW(CW), .MAXPEND(MAXPEND)) u_cnt (
            .CLOCK     (CLOCK),
            .RESET     (RESET),
            .inc       (inc[i]),
            .dec       (dec[i]),
            .clr       (sb.flush),
            .cnt       (cnt[i]),
            .underflow (uflow[i])
        );
    end

    // A same-cycle writeback retires one pending write, so a count of 1 on a source,
    // or a saturated destination, no longer blocks issue.
    always_comb begin
        logic [AW-1:0] s;
        s   = '0;
        rdy = !sb.flush;
        for (int k = 0; k < NRD; k++) begin
            s = sb.issue_src[k*AW +: AW];
            if (s != '0) begin
                if (cnt[s] > CW'(1)) rdy = 1'b0;
                else if ((cnt[s] == CW'(1)) && !(wb_en && (sb.wb_reg == s))) rdy = 1'b0;
            end
        end
        if ((sb.issue_dst != '0) && (cnt[sb.issue_dst] == CNT_MAX) &&
            !(wb_en && (sb.wb_reg == sb.issue_dst))) rdy = 1'b0;
    end

    always_comb begin
        logic [AW-1:0] s;
        s          = '0;
        sb.rd_data = '0;
        for (int k = 0; k < NRD; k++) begin
            s = sb.issue_src[k*AW +: AW];
            if (wb_en && (sb.wb_reg == s)) sb.rd_data[k*XLEN +: XLEN] = sb.wb_data;
            else                           sb.rd_data[k*XLEN +: XLEN] = regs[s];
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 1; i < NREG; i++) busy = busy | (cnt[i] != '0);
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) err <= 1'b0;
        else if (|uflow) err <= 1'b1;
    end

    assign sb.issue_ready   = rdy;
    assign sb.busy          = busy;
    assign sb.err_underflow = err;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: driver pushes model expectations, monitor pops and compares.
module tb_regfile_scoreboard;
    import cpu_pkg::*;

    localparam int XLEN = 32, NREG = 32, NRD = 2, MAXPEND = 3;
    localparam int AW = aw_f(NREG);

    logic CLOCK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLOCK = ~CLOCK;

    regfile_scoreboard_if #(.XLEN(XLEN), .NRD(NRD), .AW(AW)) sb ();

    regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .MAXPEND(MAXPEND)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .sb    (sb)
    );

    typedef struct {
        logic                rdy;
        logic [NRD*XLEN-1:0] rd;
        logic                busy;
        logic                err;
        string               tag;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    // Reference state: how many writes each register still owes, its value, sticky error.
    int              pend [NREG];
    logic [XLEN-1:0] mem  [NREG];
    bit              err_m;

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) begin
            pend[i] = 0;
            mem[i]  = '0;
        end
        err_m = 1'b0;
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < NREG; i++) if (pend[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        sb.issue_valid = 1'b0;
        sb.issue_dst   = '0;
        sb.issue_src   = '0;
        sb.wb_valid    = 1'b0;
        sb.wb_reg      = '0;
        sb.wb_data     = '0;
        sb.flush       = 1'b0;
    endtask

    // One cycle: drive at negedge, push what the DUT must show, then advance the model.
    task automatic step(input bit v, input int dst, input int s0, input int s1,
                        input bit wv, input int wr, input logic [XLEN-1:0] wd,
                        input bit fl, input string tag);
        exp_t e;
        int   src [NRD];
        bit   hit, ok;
        @(negedge CLOCK);
        src[0] = s0;
        src[1] = s1;
        sb.issue_valid = v;
        sb.issue_dst   = AW'(dst);
        sb.issue_src   = {AW'(s1), AW'(s0)};
        sb.wb_valid    = wv;
        sb.wb_reg      = AW'(wr);
        sb.wb_data     = wd;
        sb.flush       = fl;

        hit = wv && (wr != 0);
        ok  = !fl;
        for (int k = 0; k < NRD; k++) begin
            if (src[k] != 0) begin
                if (pend[src[k]] > 1) ok = 1'b0;
                if (pend[src[k]] == 1 && !(hit && wr == src[k])) ok = 1'b0;
            end
        end
        if (dst != 0 && pend[dst] == MAXPEND && !(hit && wr == dst)) ok = 1'b0;

        e.rdy = ok;
        e.rd  = '0;
        for (int k = 0; k < NRD; k++) begin
            if (src[k] == 0)                e.rd[k*XLEN +: XLEN] = '0;
            else if (hit && wr == src[k])   e.rd[k*XLEN +: XLEN] = wd;
            else                            e.rd[k*XLEN +: XLEN] = mem[src[k]];
        end
        e.busy = any_pending();
        e.err  = err_m;
        e.tag  = tag;
        q.push_back(e);

        if (hit) mem[wr] = wd;
        if (fl) begin
            for (int i = 0; i < NREG; i++) pend[i] = 0;
        end else begin
            if (hit && pend[wr] == 0) err_m = 1'b1;
            if (v && ok && dst != 0 && hit && dst == wr) begin
                // issue and retire of the same register cancel out
            end else begin
                if (v && ok && dst != 0) pend[dst]++;
                if (hit && pend[wr] > 0) pend[wr]--;
            end
        end
    endtask

    task automatic do_reset(input string tag);
        exp_t e;
        @(negedge CLOCK);
        RESET = 1'b0;
        drive_idle();
        model_clear();
        e.rdy  = 1'b1;
        e.rd   = '0;
        e.busy = 1'b0;
        e.err  = 1'b0;
        e.tag  = tag;
        q.push_back(e);
        @(negedge CLOCK);
        RESET = 1'b1;
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 0, 0, 0, '0, 0, tag);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLOCK);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.tag, ".ready"}, 64'(sb.issue_ready), 64'(e.rdy));
                chk({e.tag, ".rd_data"}, 64'(sb.rd_data), 64'(e.rd));
                chk({e.tag, ".busy"}, 64'(sb.busy), 64'(e.busy));
                chk({e.tag, ".err"}, 64'(sb.err_underflow), 64'(e.err));
            end
        end
    end

    initial begin : driver
        int wait_cnt;
        drive_idle();
        model_clear();
        do_reset("reset");

        // single issue, then hazard resolved by a same-cycle writeback
        step(1, 5, 1, 2, 0, 0, '0, 0, "issue5");
        idle("busy5");
        step(1, 0, 5, 0, 0, 0, '0, 0, "raw5_stall");
        step(1, 0, 5, 0, 1, 5, 32'hDEADBEEF, 0, "raw5_bypass");
        idle("clear5");

        // saturation of register 7
        do_reset("reset7");
        repeat (3) step(1, 7, 0, 0, 0, 0, '0, 0, "issue7");
        step(1, 7, 0, 0, 0, 0, '0, 0, "sat7");
        step(1, 7, 0, 0, 1, 7, 32'h0000_0777, 0, "sat7_wb");
        step(1, 7, 0, 0, 0, 0, '0, 0, "sat7_again");
        step(1, 0, 7, 0, 0, 0, '0, 0, "src7_pend3");

        // underflow is sticky until reset
        do_reset("reset9");
        step(0, 0, 0, 0, 1, 9, 32'h1234_5678, 0, "wb9_uflow");
        step(0, 0, 9, 0, 0, 0, '0, 0, "rd9");
        repeat (3) idle("err_hold");
        do_reset("reset_err");

        // flush with a concurrent writeback
        step(1, 3, 0, 0, 0, 0, '0, 0, "iss3a");
        step(1, 3, 0, 0, 0, 0, '0, 0, "iss3b");
        step(1, 4, 0, 0, 0, 0, '0, 0, "iss4");
        step(1, 0, 3, 4, 1, 3, 32'hCAFE_F00D, 1, "flush");
        step(1, 0, 3, 4, 0, 0, '0, 0, "post_flush");

        // register zero
        step(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, "wb0");
        step(0, 0, 0, 0, 0, 0, '0, 0, "rd0");
        step(1, 0, 0, 0, 0, 0, '0, 0, "iss0");
        idle("busy0");

        // random traffic on a narrow register window so hazards are frequent
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd_reset");
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                     $urandom, $urandom_range(0, 15) == 0, "rnd");
            end
        end

        @(negedge CLOCK);
        drive_idle();
        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 20) begin
            @(negedge CLOCK);
            wait_cnt++;
        end
        #3;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the register data width in bits.
REQ-002 The block SHALL have parameter NREG, default 32, meaning the register count; AW = clog2(NREG).
REQ-003 The block SHALL have parameter NRD, default 2, meaning the number of source read ports.
REQ-004 The block SHALL have parameter MAXPEND, default 3, meaning the maximum outstanding writes per register; CW = clog2(MAXPEND+1).
REQ-005 The block SHALL have port CLOCK, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port RESET, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port issue_valid, input, 1 bit: an instruction is presented for issue.
REQ-008 The block SHALL have port issue_dst, input, AW bits: the destination register of the issuing instruction; 0 means no write.
REQ-009 The block SHALL have port issue_src, input, NRD*AW bits: the source registers; port k occupies bits [k*AW +: AW].
REQ-010 The block SHALL have port issue_ready, output, 1 bit: issue is accepted this cycle.
REQ-011 The block SHALL have port rd_data, output, NRD*XLEN bits: the source operand values, packed in the same order as issue_src.
REQ-012 The block SHALL have port wb_valid, input, 1 bit: a writeback is presented.
REQ-013 The block SHALL have port wb_reg, input, AW bits: the writeback destination register.
REQ-014 The block SHALL have port wb_data, input, XLEN bits: the writeback value.
REQ-015 The block SHALL have port flush, input, 1 bit: discard all pending-write tracking.
REQ-016 The block SHALL have port busy, output, 1 bit: at least one pending counter is nonzero.
REQ-017 The block SHALL have port err_underflow, output, 1 bit: sticky flag, set on a writeback to a register with no pending write.

Function
REQ-018 Register 0 SHALL read as 0, SHALL ignore writes and SHALL never become pending.
REQ-019 Reads SHALL be combinational: rd_data[k] is the stored value of src k, unless wb_valid is high and wb_reg equals src k (nonzero), in which case rd_data[k] SHALL equal wb_data in the same cycle (write-through bypass).
REQ-020 A writeback with wb_valid high and wb_reg nonzero SHALL update storage at the next rising edge, regardless of counter state or flush.
REQ-021 Each register SHALL have a CW-bit pending counter.
REQ-022 Issue SHALL fire when issue_valid and issue_ready are both high.
REQ-023 When issue fires and issue_dst is nonzero, the counter of issue_dst SHALL increment.
REQ-024 A writeback with wb_valid high, nonzero wb_reg and a nonzero counter SHALL decrement that register's counter.
REQ-025 When issue fires and a writeback targets the same register in the same cycle, that register's counter SHALL remain unchanged.
REQ-026 issue_ready SHALL be 0 when flush is high.
REQ-027 issue_ready SHALL be 0 when any nonzero src k has counter > 1.
REQ-028 issue_ready SHALL be 0 when any nonzero src k has counter == 1 and is not the target of this cycle's writeback (a counter of 1 resolved by a same-cycle writeback SHALL NOT block issue).
REQ-029 issue_ready SHALL be 0 when issue_dst is nonzero and its counter == MAXPEND (saturation; the counter never wraps).
REQ-030 issue_ready SHALL be combinational from the current counters and the wb_* and flush inputs, and SHALL NOT depend on issue_valid.
REQ-031 A writeback with wb_valid high and nonzero wb_reg whose counter is 0 SHALL still write the data, SHALL leave the counter at 0, and SHALL set err_underflow at the next edge.
REQ-032 err_underflow SHALL clear only on reset.
REQ-033 When flush is high, all counters SHALL become 0 at the next edge; a writeback in the same cycle SHALL write data and SHALL NOT set err_underflow.
REQ-034 busy SHALL be registered-state derived: the OR of all counters being nonzero, with no input dependence.

Reset
REQ-035 While RESET is low, all registers SHALL be 0, all counters 0 and err_underflow 0, asynchronously.
REQ-036 While RESET is low, issue_ready SHALL follow REQ-026 to REQ-030 on the zeroed state, and busy SHALL be 0.
REQ-037 Reset deassertion SHALL take effect at the first rising edge with RESET high.
REQ-038 A pending writeback coinciding with reset SHALL be lost.

Structure
REQ-039 The parameter defaults and the AW/CW width functions SHALL live in a shared package cpu_pkg, reused by the ID stage.
REQ-040 One sub-module, sb_counter (a single saturating up/down counter with inc, dec, clr, underflow outputs), SHALL be instantiated NREG-1 times.
REQ-041 Storage SHALL be a flop array; no memory macro SHALL be used.

Verification
REQ-042 Reset, then issue dst=5 with src={1,2} -> issue_ready=1, counter[5]=1, busy=1.
REQ-043 With counter[5]=1, issue src={5,0} with no wb -> issue_ready=0; in the same cycle present wb_reg=5, wb_data=32'hDEADBEEF -> issue_ready=1, rd_data[0]=32'hDEADBEEF, counter[5]=0 next cycle.
REQ-044 Issue dst=7 three times with no wb -> counter[7]=3; a fourth issue to dst=7 -> issue_ready=0; one wb to register 7 plus a simultaneous issue to dst=7 -> counter stays 3.
REQ-045 wb_reg=9 with counter[9]=0 -> data stored, err_underflow=1 and held until RESET low.
REQ-046 With counters 3=2 and 4=1, assert flush with wb_reg=3 -> issue_ready=0 that cycle; next cycle all counters 0, busy=0, reg[3]=wb_data, err_underflow=0.
REQ-047 wb_reg=0 with wb_data=32'hFFFFFFFF, then read src=0 -> rd_data=0; issue dst=0 -> busy stays 0.
